// File: rtl/cmp_search_pkg.sv
// Shared types for the compare-search initiator: FSM state encoding and the
// largest comparator latency the wait counter is sized for.
package cmp_search_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        EVAL,
        DONE
    } search_state_t;

    localparam int CMP_LAT_MAX = 7;

endpackage

// File: rtl/cmp_search_ctrl.sv
// Binary-search initiator for a registered lt/eq/gt comparator: drives probe values
// at an externally held target and reports the located value.
module cmp_search_ctrl
    import cmp_search_pkg::*;
#(
    parameter int N       = 8,
    parameter int CMP_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] lo_init,
    input  logic [N-1:0] hi_init,
    output logic [N-1:0] probe,
    input  logic         cmp_lt,
    input  logic         cmp_eq,
    input  logic         cmp_gt,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic         err,
    output logic [N-1:0] result
);

    localparam int                WCNT_W      = $clog2(CMP_LAT_MAX + 1);
    localparam logic [WCNT_W-1:0] WCNT_RELOAD = WCNT_W'(CMP_LAT - 1);

    search_state_t     state_q, state_d;
    logic [N:0]        lo_q, lo_d, hi_q, hi_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [N-1:0]      probe_q, probe_d, result_q, result_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              found_q, found_d, err_q, err_d;
    logic [N:0]        probe_x, lo_step, hi_step;

    function automatic logic [N-1:0] mid_of(input logic [N:0] lo, input logic [N:0] hi);
        return N'(lo + ((hi - lo) >> 1));
    endfunction

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        wcnt_d   = wcnt_q;
        probe_d  = probe_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        found_d  = found_q;
        err_d    = err_q;
        probe_x  = {1'b0, probe_q};
        lo_step  = probe_x + (N+1)'(1);
        hi_step  = probe_x - (N+1)'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                    if (lo_init <= hi_init) begin
                        lo_d    = {1'b0, lo_init};
                        hi_d    = {1'b0, hi_init};
                        probe_d = mid_of({1'b0, lo_init}, {1'b0, hi_init});
                        wcnt_d  = WCNT_RELOAD;
                        busy_d  = 1'b1;
                        state_d = WAIT;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = EVAL;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            EVAL: begin
                case ({cmp_lt, cmp_eq, cmp_gt})
                    3'b010: begin
                        found_d  = 1'b1;
                        result_d = probe_q;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                    3'b100, 3'b001: begin
                        if (cmp_lt) begin
                            lo_d = lo_step;
                        end else begin
                            hi_d = hi_step;
                        end
                        // Stepping past the bound the probe sits on empties the range;
                        // decided before hi_step can underflow at probe 0.
                        if ((cmp_lt && probe_x == hi_q) || (cmp_gt && probe_x == lo_q)) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            probe_d = cmp_lt ? mid_of(lo_step, hi_q) : mid_of(lo_q, hi_step);
                            wcnt_d  = WCNT_RELOAD;
                            state_d = WAIT;
                        end
                    end
                    default: begin
                        err_d   = 1'b1;
                        found_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                endcase
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            wcnt_q   <= '0;
            probe_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            wcnt_q   <= wcnt_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign probe  = probe_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign found  = found_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Bench for cmp_search_ctrl: one instance at CMP_LAT=1 and one at CMP_LAT=3, each
// behind a registered comparator pipeline, checked against a scoreboard of searches.
module tb_cmp_search_ctrl;

    localparam int N  = 8;
    localparam int NI = 2;

    typedef struct {
        bit found;
        bit err;
        int result;
        int lat;
        int nprobes;
        int start_edge;
    } res_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [NI-1:0]  start_v;
    logic [N-1:0]   lo_init, hi_init, target;
    logic           ovr_en;
    logic [2:0]     ovr_flags;
    logic [N-1:0]   probe_w  [NI];
    logic [N-1:0]   result_w [NI];
    logic [NI-1:0]  busy_w, done_w, found_w, err_w;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    res_t res_q0[$];
    res_t res_q1[$];
    int   prb_q0[$];
    int   prb_q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic void push_res(input int i, input res_t r);
        if (i == 0) res_q0.push_back(r); else res_q1.push_back(r);
    endfunction

    function automatic res_t pop_res(input int i);
        if (i == 0) return res_q0.pop_front();
        return res_q1.pop_front();
    endfunction

    function automatic int res_size(input int i);
        return (i == 0) ? res_q0.size() : res_q1.size();
    endfunction

    function automatic void push_prb(input int i, input int v);
        if (i == 0) prb_q0.push_back(v); else prb_q1.push_back(v);
    endfunction

    function automatic int pop_prb(input int i);
        if (i == 0) return prb_q0.pop_front();
        return prb_q1.pop_front();
    endfunction

    function automatic int prb_size(input int i);
        return (i == 0) ? prb_q0.size() : prb_q1.size();
    endfunction

    function automatic void flush_all();
        res_q0.delete();
        res_q1.delete();
        prb_q0.delete();
        prb_q1.delete();
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 1 : 3;
        logic [2:0] pipe_q [LAT];
        logic [2:0] flags;

        // Registered comparator: probe on a, target on b, LAT stages deep.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < LAT; k++) pipe_q[k] <= 3'b000;
            end else begin
                pipe_q[0] <= {probe_w[gi] < target, probe_w[gi] == target, probe_w[gi] > target};
                for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
            end
        end

        assign flags = ovr_en ? ovr_flags : pipe_q[LAT-1];

        cmp_search_ctrl #(.N(N), .CMP_LAT(LAT)) u_dut (
            .clk    (clk),
            .rst    (rst),
            .start  (start_v[gi]),
            .lo_init(lo_init),
            .hi_init(hi_init),
            .probe  (probe_w[gi]),
            .cmp_lt (flags[2]),
            .cmp_eq (flags[1]),
            .cmp_gt (flags[0]),
            .busy   (busy_w[gi]),
            .done   (done_w[gi]),
            .found  (found_w[gi]),
            .err    (err_w[gi]),
            .result (result_w[gi])
        );

        initial begin : mon
            logic       pbusy;
            logic       pdone;
            logic [N-1:0] pprobe;
            int         nprb;
            res_t       r;
            pbusy  = 1'b0;
            pdone  = 1'b0;
            pprobe = '0;
            nprb   = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    pbusy = 1'b0;
                    pdone = 1'b0;
                    nprb  = 0;
                end else begin
                    if (busy_w[gi] && (!pbusy || probe_w[gi] != pprobe)) begin
                        if (prb_size(gi) == 0)
                            check_eq($sformatf("L%0d_unexpected_probe", LAT), int'(busy_w[gi]), 0);
                        else
                            check_eq($sformatf("L%0d_probe%0d", LAT, nprb), int'(probe_w[gi]), pop_prb(gi));
                        nprb++;
                    end
                    if (pdone) begin
                        check_eq($sformatf("L%0d_done_pulse", LAT), int'(done_w[gi]), 0);
                        check_eq($sformatf("L%0d_busy_after_done", LAT), int'(busy_w[gi]), 0);
                    end
                    if (done_w[gi] && !pdone) begin
                        if (res_size(gi) == 0) begin
                            check_eq($sformatf("L%0d_spurious_done", LAT), int'(done_w[gi]), 0);
                        end else begin
                            r = pop_res(gi);
                            check_eq($sformatf("L%0d_found", LAT), int'(found_w[gi]), int'(r.found));
                            check_eq($sformatf("L%0d_err", LAT), int'(err_w[gi]), int'(r.err));
                            check_eq($sformatf("L%0d_result", LAT), int'(result_w[gi]), r.result);
                            check_eq($sformatf("L%0d_latency", LAT), cyc - r.start_edge, r.lat);
                            check_eq($sformatf("L%0d_nprobes", LAT), nprb, r.nprobes);
                            $display("L%0d search: found=%0d err=%0d result=%0d probes=%0d latency=%0d",
                                     LAT, found_w[gi], err_w[gi], result_w[gi], nprb, cyc - r.start_edge);
                        end
                        nprb = 0;
                    end
                    pbusy  = busy_w[gi];
                    pdone  = done_w[gi];
                    pprobe = probe_w[gi];
                end
            end
        end
    end

    task automatic check_idle(input string tag);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("%s_L%0d_probe", tag, lat_of(i)), int'(probe_w[i]), 0);
            check_eq($sformatf("%s_L%0d_busy", tag, lat_of(i)), int'(busy_w[i]), 0);
            check_eq($sformatf("%s_L%0d_done", tag, lat_of(i)), int'(done_w[i]), 0);
            check_eq($sformatf("%s_L%0d_found", tag, lat_of(i)), int'(found_w[i]), 0);
            check_eq($sformatf("%s_L%0d_err", tag, lat_of(i)), int'(err_w[i]), 0);
            check_eq($sformatf("%s_L%0d_result", tag, lat_of(i)), int'(result_w[i]), 0);
        end
    endtask

    // hold keeps start high until one cycle past done; abort_at>0 resets mid-search.
    task automatic run_search(input int lo, input int hi, input int tgt, input bit hold, input int abort_at);
        int   l, h, m, ev;
        bit   fnd, er;
        int   prb[$];
        res_t r;
        logic [NI-1:0] done_prev;
        l = lo; h = hi; ev = 0; fnd = 1'b0; er = 1'b0;
        while (l <= h) begin
            m = (l + h) / 2;
            prb.push_back(m);
            ev++;
            if (ovr_en) begin er = 1'b1; break; end
            if (m == tgt) begin fnd = 1'b1; break; end
            if (m < tgt) l = m + 1; else h = m - 1;
        end
        for (int i = 0; i < NI; i++) begin
            r.found      = fnd;
            r.err        = er;
            r.result     = fnd ? tgt : 0;
            r.nprobes    = prb.size();
            r.lat        = (lo <= hi) ? ev * (lat_of(i) + 1) : 0;
            r.start_edge = cyc + 1;
            push_res(i, r);
            foreach (prb[k]) push_prb(i, prb[k]);
        end
        lo_init = N'(lo);
        hi_init = N'(hi);
        target  = N'(tgt);
        start_v = '1;
        @(negedge clk);
        if (hold) begin
            lo_init = 8'd0;
            hi_init = 8'd1;
        end else begin
            start_v = '0;
        end
        done_prev = '0;
        for (int t = 0; t < 300; t++) begin
            if (abort_at > 0 && t == abort_at) begin
                rst = 1'b1;
                flush_all();
                @(negedge clk);
                check_idle("abort");
                rst = 1'b0;
                break;
            end
            if (res_size(0) == 0 && res_size(1) == 0) break;
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (done_prev[i]) start_v[i] = 1'b0;
                done_prev[i] = done_w[i];
            end
        end
        check_eq("search_timeout", res_size(0) + res_size(1), 0);
        flush_all();
        start_v = '0;
        repeat (3) @(negedge clk);
        check_eq("idle_busy", int'(busy_w), 0);
    endtask

    initial begin
        rst       = 1'b1;
        start_v   = '0;
        lo_init   = '0;
        hi_init   = '0;
        target    = '0;
        ovr_en    = 1'b0;
        ovr_flags = 3'b000;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        run_search(0, 255, 8'h5A, 1'b0, 0);
        run_search(0, 255, 255, 1'b0, 0);
        run_search(0, 255, 0, 1'b0, 0);
        run_search(10, 20, 30, 1'b0, 0);
        run_search(9, 3, 8'h10, 1'b0, 0);
        run_search(10, 20, 5, 1'b0, 0);
        run_search(0, 0, 5, 1'b0, 0);
        run_search(255, 255, 255, 1'b0, 0);
        run_search(77, 77, 77, 1'b0, 0);

        ovr_en    = 1'b1;
        ovr_flags = 3'b101;
        run_search(0, 255, 8'h40, 1'b0, 0);
        ovr_flags = 3'b000;
        run_search(0, 255, 8'h40, 1'b0, 0);
        ovr_en    = 1'b0;

        run_search(0, 255, 8'h5A, 1'b0, 4);
        run_search(0, 255, 8'h5A, 1'b0, 0);
        run_search(0, 255, 8'h33, 1'b1, 0);

        for (int k = 0; k < 8; k++) begin
            int lo, hi, tgt;
            lo  = int'($urandom_range(0, 255));
            hi  = int'($urandom_range(lo, 255));
            tgt = int'($urandom_range(0, 255));
            run_search(lo, hi, tgt, 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
